// File: rtl/srec_word_packer.sv
// srec_word_packer: merges the parser's byte-write stream into 32-bit word
// writes with byte enables, flushing partial words on demand or when idle.
module srec_word_packer #(
   parameter bit BIG_ENDIAN    = 1'b0,
   parameter int FLUSH_TIMEOUT = 1024
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] write_address,
   input  logic [7:0]  write_byte,
   input  logic        write_enable,
   input  logic        flush,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [29:0] mem_address,
   output logic [31:0] mem_data,
   output logic [3:0]  mem_byte_enable,
   output logic        overflow,
   output logic [15:0] word_count
);

   localparam int CW = (FLUSH_TIMEOUT > 2) ? $clog2(FLUSH_TIMEOUT) : 1;
   localparam logic [CW-1:0] IDLE_LAST = CW'(FLUSH_TIMEOUT - 1);

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } word_t;

   logic        acc_valid;
   word_t       acc;
   logic        acc_valid_n;
   word_t       acc_n;

   logic        flush_pending;
   logic        flush_pending_n;
   logic [CW-1:0] idle_cnt;
   logic [CW-1:0] idle_cnt_n;

   logic [1:0]  lane;
   logic [3:0]  lane_oh;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;
   logic [29:0] wr_word;
   logic        same_word;
   logic        collision;
   logic [3:0]  merged_be;
   logic [31:0] merged_data;

   logic        flush_req;
   logic        idle_hit;
   logic        emit;
   word_t       emit_word;
   logic        out_free;
   logic        handshake;

   // byte lane decode for the incoming byte
   always_comb begin
      if (BIG_ENDIAN)
         lane = 2'd3 - write_address[1:0];
      else
         lane = write_address[1:0];
      lane_oh   = 4'b0001 << lane;
      lane_mask = {{8{lane_oh[3]}}, {8{lane_oh[2]}},
                   {8{lane_oh[1]}}, {8{lane_oh[0]}}};
      lane_data = {4{write_byte}} & lane_mask;
      wr_word   = write_address[31:2];
   end

   always_comb begin
      same_word   = acc_valid && (acc.addr == wr_word);
      collision   = |(acc.be & lane_oh);
      merged_be   = acc.be | lane_oh;
      merged_data = (acc.data & ~lane_mask) | lane_data;
      flush_req   = flush | flush_pending;
      idle_hit    = (idle_cnt == IDLE_LAST);
   end

   // accumulator next state and emission select
   always_comb begin
      acc_valid_n     = acc_valid;
      acc_n           = acc;
      emit            = 1'b0;
      emit_word       = acc;
      flush_pending_n = 1'b0;

      if (write_enable) begin
         flush_pending_n = flush_req;
         if (same_word && !collision) begin
            if (merged_be == 4'hF) begin
               emit           = 1'b1;
               emit_word.data = merged_data;
               emit_word.be   = 4'hF;
               acc_valid_n    = 1'b0;
               acc_n          = '0;
            end else begin
               acc_n.data = merged_data;
               acc_n.be   = merged_be;
            end
         end else begin
            // different word or lane collision: old word out, new one in
            emit        = acc_valid;
            acc_valid_n = 1'b1;
            acc_n.addr  = wr_word;
            acc_n.data  = lane_data;
            acc_n.be    = lane_oh;
         end
      end else if (acc_valid && (flush_req || idle_hit)) begin
         emit        = 1'b1;
         acc_valid_n = 1'b0;
         acc_n       = '0;
      end
   end

   always_comb begin
      if (write_enable || emit || !acc_valid)
         idle_cnt_n = '0;
      else
         idle_cnt_n = idle_cnt + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         acc_valid     <= 1'b0;
         acc           <= '0;
         flush_pending <= 1'b0;
         idle_cnt      <= '0;
      end else begin
         acc_valid     <= acc_valid_n;
         acc           <= acc_n;
         flush_pending <= flush_pending_n;
         idle_cnt      <= idle_cnt_n;
      end
   end

   assign out_free  = !mem_valid || mem_ready;
   assign handshake = mem_valid && mem_ready;

   // output register: the parser cannot stall, so a blocked emit is lost
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         mem_valid       <= 1'b0;
         mem_address     <= '0;
         mem_data        <= '0;
         mem_byte_enable <= '0;
         overflow        <= 1'b0;
         word_count      <= '0;
      end else begin
         if (emit && out_free) begin
            mem_valid       <= 1'b1;
            mem_address     <= emit_word.addr;
            mem_data        <= emit_word.data;
            mem_byte_enable <= emit_word.be;
         end else if (handshake) begin
            mem_valid <= 1'b0;
         end
         if (emit && !out_free)
            overflow <= 1'b1;
         if (handshake)
            word_count <= word_count + 16'd1;
      end
   end

endmodule

// File: doc/srec_word_packer.md
Name: srec_word_packer

Overview:
- Sits directly downstream of srec_parser and consumes its byte-write stream (write_address, write_byte, write_enable).
- Merges consecutive bytes into 32-bit word writes with byte enables for the program memory.
- Flushes partial words on address discontinuity, explicit flush, or idle timeout.
- Flags overflow when memory backpressure would lose a word, since the parser cannot be stalled.

Parameters:
- BIG_ENDIAN, 0, lane select: 0 → lane = addr[1:0]; 1 → lane = 3 - addr[1:0].
- FLUSH_TIMEOUT, 1024, idle cycles with a pending partial word before auto-flush (≥2).

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- write_address  input  32  byte address from parser
- write_byte  input  8  byte data from parser
- write_enable  input  1  single-cycle byte strobe from parser
- flush  input  1  force emission of pending partial word
- mem_valid  output  1  word write pending on mem_*
- mem_ready  input  1  memory accepts word when mem_valid & mem_ready
- mem_address  output  30  word address (byte address [31:2])
- mem_data  output  32  word data; byte lane k = bits [8k+7:8k]
- mem_byte_enable  output  4  valid lanes of mem_data
- overflow  output  1  sticky: a word was dropped
- word_count  output  16  count of words accepted by memory, wraps

Behaviour:
- Reset (reset_n low at clock edge): mem_valid=0, mem_address=0, mem_data=0, mem_byte_enable=0, overflow=0, word_count=0, accumulator empty, idle counter=0, flush_pending=0. Reset mid-operation discards pending and output words.
- Accumulator state: acc_valid, acc_addr[29:0], acc_data[31:0], acc_be[3:0].
- Byte accept (write_enable=1 at edge N):
  - Accumulator empty: load acc_addr = write_address[31:2], lane byte, acc_be = one-hot lane.
  - Same word and lane bit clear: merge byte into lane and set the be bit.
  - Different word, or lane already set (collision): emit old accumulator, then load new byte.
- Full word: when acc_be becomes 4'b1111 after a merge, emit at once; the accumulator becomes empty.
- Emission latency: an emitted word is on mem_* with mem_valid=1 from cycle N+1.
- Output stage:
  - Loads on emit when !mem_valid or mem_ready that cycle (back-to-back allowed).
  - Holds mem_* stable while mem_valid & !mem_ready.
  - mem_valid clears after the handshake unless reloaded the same cycle.
- Overflow: emit while mem_valid & !mem_ready → word dropped, overflow=1 (sticky until reset). The accumulator still updates normally.
- word_count increments on each mem_valid & mem_ready; 16'hFFFF → 0.
- flush with no write_enable: emit accumulator if valid, else no-op.
- flush and write_enable in the same cycle: process the byte normally, set flush_pending, and flush the next cycle.
- Idle timeout:
  - Idle counter resets on any write_enable or emission.
  - It increments each cycle while acc_valid & !write_enable.
  - Reaching FLUSH_TIMEOUT-1 emits the partial word.
  - The counter does not run while the accumulator is empty.
- Address wrap: 32'hFFFFFFFF is lane 3 of word 30'h3FFFFFFF; next address 0 is a different word (normal emission).
- At most one emission per cycle: a collision emit plus a full-word completion cannot coincide, because the new byte starts a fresh accumulator with one lane.

Test Plan:
- BIG_ENDIAN=0; bytes 11,22,33,44 at addr 0x100..0x103 on consecutive cycles, mem_ready=1 → one word, mem_address=0x40, mem_data=0x44332211, be=4'b1111, mem_valid 1 cycle after the 4th byte; word_count=1.
- Bytes AA@0x201, BB@0x202, then CC@0x300 → word addr 0x80, data 0x00BBAA00, be=4'b0110; CC pending. After FLUSH_TIMEOUT idle cycles → addr 0xC0, data 0x000000CC, be=4'b0001.
- Byte 55@0x10 with flush in the same cycle → next cycle flush_pending, then mem_valid with addr 0x4, data 0x00000055, be=4'b0001; exactly one word.
- mem_ready=0 held; complete two full words back-to-back → first held stable on mem_*, second dropped, overflow=1; release mem_ready → one handshake, word_count=1.
- BIG_ENDIAN=1; bytes 11,22,33,44 at 0x0..0x3 → mem_data=0x11223344. Collision: 77@0x5 then 88@0x5 → emits be=4'b0100 word with 77, 88 pending.
- Assert reset_n=0 with a partial word and mem_valid=1 → next cycle all outputs zero; subsequent flush emits nothing.
